// File: rtl/spart_rx.sv
// SPART receiver: 16x oversampled 8N1 deserialiser with a one-entry receive buffer.
// Frames are qualified at the start-bit centre and captured at each data/stop-bit centre.
module spart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    input  logic [15:0]          divisor,
    input  logic                 receive_read_en,
    output logic [DATA_BITS-1:0] receive_read_line,
    output logic                 rda,
    output logic                 framing_err,
    output logic                 overrun
);

    localparam int SYNC_STAGES = 2;
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [SW-1:0] HALF_CNT = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] LAST_CNT = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rx_s;
    logic [15:0]            tick_cnt_reg;
    logic                   tick;

    state_t                 state_reg, state_next;
    logic [SW-1:0]          sample_cnt_reg, sample_cnt_next;
    logic [BW-1:0]          bit_cnt_reg, bit_cnt_next;
    logic [DATA_BITS-1:0]   shift_reg, shift_next;
    logic                   load, frame_bad;

    logic [DATA_BITS-1:0]   line_reg;
    logic                   rda_reg, framing_err_reg, overrun_reg;

    // Two-flop synchroniser; resets to the idle-high line level.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    sync_reg[gi] <= 1'b1;
                else if (gi == 0)
                    sync_reg[gi] <= rxd;
                else
                    sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi - 1];
            end
        end
    endgenerate

    assign rx_s = sync_reg[SYNC_STAGES-1];

    // Divisor is only sampled on reload, so a change never disturbs the running count.
    assign tick = (tick_cnt_reg == 16'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tick_cnt_reg <= 16'd0;
        else if (tick)
            tick_cnt_reg <= divisor;
        else
            tick_cnt_reg <= tick_cnt_reg - 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            sample_cnt_reg <= '0;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            sample_cnt_reg <= sample_cnt_next;
            bit_cnt_reg    <= bit_cnt_next;
            shift_reg      <= shift_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        sample_cnt_next = sample_cnt_reg;
        bit_cnt_next    = bit_cnt_reg;
        shift_next      = shift_reg;
        load            = 1'b0;
        frame_bad       = 1'b0;
        if (tick) begin
            case (state_reg)
                IDLE: begin
                    if (!rx_s) begin
                        state_next      = START;
                        sample_cnt_next = '0;
                    end
                end
                START: begin
                    if (sample_cnt_reg == HALF_CNT) begin
                        sample_cnt_next = '0;
                        // A line that is high again at the start-bit centre was a glitch.
                        if (!rx_s) begin
                            state_next   = DATA;
                            bit_cnt_next = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        sample_cnt_next = sample_cnt_reg + SW'(1);
                    end
                end
                DATA: begin
                    if (sample_cnt_reg == LAST_CNT) begin
                        sample_cnt_next = '0;
                        shift_next      = {rx_s, shift_reg[DATA_BITS-1:1]};
                        bit_cnt_next    = bit_cnt_reg + BW'(1);
                        if (bit_cnt_reg == LAST_BIT)
                            state_next = STOP;
                    end else begin
                        sample_cnt_next = sample_cnt_reg + SW'(1);
                    end
                end
                STOP: begin
                    if (sample_cnt_reg == LAST_CNT) begin
                        // Back to IDLE at the stop-bit centre so a following start edge is not missed.
                        state_next      = IDLE;
                        sample_cnt_next = '0;
                        load            = rx_s;
                        frame_bad       = !rx_s;
                    end else begin
                        sample_cnt_next = sample_cnt_reg + SW'(1);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // A load in the same cycle as a read wins, and is not an overrun since the old byte was consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_reg        <= '0;
            rda_reg         <= 1'b0;
            framing_err_reg <= 1'b0;
            overrun_reg     <= 1'b0;
        end else begin
            if (load)
                line_reg <= shift_reg;

            if (load)
                rda_reg <= 1'b1;
            else if (receive_read_en)
                rda_reg <= 1'b0;

            if (load)
                framing_err_reg <= 1'b0;
            else if (frame_bad)
                framing_err_reg <= 1'b1;

            if (receive_read_en)
                overrun_reg <= 1'b0;
            else if (load && rda_reg)
                overrun_reg <= 1'b1;
        end
    end

    assign receive_read_line = line_reg;
    assign rda               = rda_reg;
    assign framing_err       = framing_err_reg;
    assign overrun           = overrun_reg;

endmodule

// File: tb/tb_spart_rx.sv
// Testbench for spart_rx: directed frame table, multi-cycle corner sequences and
// randomized frames compared against a frame-level model of the receive buffer.
module tb_spart_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rxd = 1'b1;
    logic [15:0] divisor = 16'd4;
    logic        receive_read_en = 1'b0;
    logic [7:0]  receive_read_line;
    logic        rda, framing_err, overrun;

    int vectors = 0;
    int miscompares = 0;
    int cyc;

    // Frame-level model of the buffer and flags.
    logic [7:0] m_line;
    bit         m_rda, m_ferr, m_ovr;

    spart_rx dut (
        .clk              (clk),
        .rst              (rst),
        .rxd              (rxd),
        .divisor          (divisor),
        .receive_read_en  (receive_read_en),
        .receive_read_line(receive_read_line),
        .rda              (rda),
        .framing_err      (framing_err),
        .overrun          (overrun)
    );

    always #5 clk = ~clk;

    // Edge counter restarted by reset; used to line stimulus up with the tick phase.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    typedef struct {
        logic [7:0] data;
        bit         stop;
        bit         rd;
        logic [7:0] e_line;
        bit         e_rda;
        bit         e_ferr;
        bit         e_ovr;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [7:0] e_line,
                                 input bit e_rda, input bit e_ferr, input bit e_ovr);
        $display("%s: line=%02h rda=%0b ferr=%0b ovr=%0b (want %02h %0b %0b %0b)", tag,
                 receive_read_line, rda, framing_err, overrun, e_line, e_rda, e_ferr, e_ovr);
        check({tag, ".line"}, receive_read_line, e_line);
        check({tag, ".rda"},  rda,               e_rda);
        check({tag, ".ferr"}, framing_err,       e_ferr);
        check({tag, ".ovr"},  overrun,           e_ovr);
    endtask

    task automatic check_model(input string tag);
        check_outputs(tag, m_line, m_rda, m_ferr, m_ovr);
    endtask

    task automatic model_reset();
        m_line = 8'h00; m_rda = 0; m_ferr = 0; m_ovr = 0;
    endtask

    task automatic model_frame(input logic [7:0] d, input bit stop);
        if (stop) begin
            if (m_rda) m_ovr = 1;
            m_line = d; m_rda = 1; m_ferr = 0;
        end else begin
            m_ferr = 1;
        end
    endtask

    task automatic model_read();
        m_rda = 0; m_ovr = 0;
    endtask

    // All drive tasks start and end just after a rising edge.
    task automatic drive_bit(input bit b);
        int bp;
        bp = 16 * (int'(divisor) + 1);
        rxd = b;
        repeat (bp) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
        // A low stop bit would look like the next start edge; restore idle first.
        if (!stop) drive_bit(1'b1);
    endtask

    task automatic pulse_read();
        receive_read_en = 1'b1;
        @(posedge clk); #1;
        receive_read_en = 1'b0;
    endtask

    initial begin
        tbl[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{8'hC3, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{8'h81, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{8'h7E, 1'b1, 1'b1, 8'h7E, 1'b1, 1'b0, 1'b0};

        // Power-on reset.
        #1 rst = 1'b1;
        #3;
        model_reset();
        check_model("reset");
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Reset mid-frame with a byte already buffered.
        send_frame(8'hE7, 1'b1);
        model_frame(8'hE7, 1'b1);
        check_model("pre_rst");
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_model("mid_rst");
        rxd = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        send_frame(8'h5A, 1'b1);
        model_frame(8'h5A, 1'b1);
        check_model("after_rst");
        pulse_read();
        model_read();
        check_model("read_5a");

        // Directed table: basic, back-to-back overrun, framing error, recovery.
        for (int i = 0; i < 5; i++) begin
            send_frame(tbl[i].data, tbl[i].stop);
            model_frame(tbl[i].data, tbl[i].stop);
            check_outputs($sformatf("tbl%0d", i), tbl[i].e_line, tbl[i].e_rda,
                          tbl[i].e_ferr, tbl[i].e_ovr);
            if (tbl[i].rd) begin
                pulse_read();
                model_read();
                check_outputs($sformatf("tbl%0d_rd", i), tbl[i].e_line, 1'b0,
                              tbl[i].e_ferr, 1'b0);
            end
        end

        // Glitch: 3 ticks low on an idle line must be ignored.
        rxd = 1'b0;
        repeat (15) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (120) @(posedge clk);
        #1;
        check_model("glitch");
        send_frame(8'h11, 1'b1);
        model_frame(8'h11, 1'b1);
        check_model("post_glitch");

        // Read exactly on the load edge: start edge aligned so its first tick is 3 edges later,
        // making the stop-bit load land 763 edges after the edge that launched the start bit.
        do begin
            @(posedge clk); #1;
        end while (cyc % 5 != 3);
        fork
            send_frame(8'h96, 1'b1);
            begin
                repeat (762) @(posedge clk);
                #1 receive_read_en = 1'b1;
                @(posedge clk);
                #1 receive_read_en = 1'b0;
            end
        join
        m_line = 8'h96; m_rda = 1; m_ferr = 0; m_ovr = 0;
        check_model("rd_and_load");

        // Randomized frames, gaps, reads and divisors against the model.
        for (int n = 0; n < 32; n++) begin
            logic [7:0] d;
            bit         stop;
            if (n % 8 == 0) begin
                divisor = 16'($urandom_range(4));
                repeat (20) @(posedge clk);
                #1;
            end
            d = 8'($urandom);
            stop = ($urandom_range(7) != 0);
            send_frame(d, stop);
            model_frame(d, stop);
            check_model($sformatf("rnd%0d", n));
            if ($urandom_range(2) == 0) begin
                pulse_read();
                model_read();
                check_model($sformatf("rnd%0d_rd", n));
            end
            if ($urandom_range(1) == 0) begin
                repeat ($urandom_range(20)) @(posedge clk);
                #1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
